// File: rtl/read_string_pkg.sv
// Shared definitions for the string read/write stages: descriptor bit
// positions, FSM state encoding, REP prefix codes and operand sizing.
package read_string_pkg;

    // Descriptor cache bit positions (x86 segment descriptor layout)
    localparam int unsigned DESC_BIT_D_B        = 54;
    localparam int unsigned DESC_BIT_TYPE_RW    = 41;  // readable (code) / writable (data)
    localparam int unsigned DESC_BIT_TYPE_ED_C  = 42;  // expand-down (data) / conforming (code)
    localparam int unsigned DESC_BIT_TYPE_CODE  = 43;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REP_NONE = 2'd0,
        REP_Z    = 2'd1,
        REP_NZ   = 2'd2
    } rep_t;

    // Operand size in bytes: 1, 2 or 4
    function automatic logic [2:0] operand_size(input logic is_8bit, input logic operand_16bit);
        if (is_8bit)            return 3'd1;
        else if (operand_16bit) return 3'd2;
        else                    return 3'd4;
    endfunction

endpackage

// File: rtl/read_string_seg_check.sv
// string_seg_check: combinational segment limit / access check for one
// string operand access.
//   offset       in  32  effective offset within the segment
//   length_m1    in  3   access length minus one (0..3)
//   cache        in  64  segment descriptor cache
//   limit        in  32  segment limit
//   is_write     in  1   1 = write access, 0 = read access
//   limit_fault  out 1   access not fully inside the segment
//   access_fault out 1   segment type forbids this access
module string_seg_check
    import read_string_pkg::*;
(
    input  logic [31:0] offset,
    input  logic [2:0]  length_m1,
    input  logic [63:0] cache,
    input  logic [31:0] limit,
    input  logic        is_write,
    output logic        limit_fault,
    output logic        access_fault
);

    logic [31:0] upper;
    logic [31:0] len_ext;
    logic        is_code;
    logic        expand_down;
    logic        rw_bit;

    logic unused_cache_bits;
    assign unused_cache_bits = ^{cache[63:55], cache[53:44], cache[40:0]};

    always_comb begin
        is_code     = cache[DESC_BIT_TYPE_CODE];
        expand_down = cache[DESC_BIT_TYPE_ED_C];
        rw_bit      = cache[DESC_BIT_TYPE_RW];
        upper       = cache[DESC_BIT_D_B] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        len_ext     = {29'd0, length_m1};

        if (is_code || !expand_down) begin
            // off > limit also makes limit-off wrap large, so both terms are needed
            limit_fault = (offset > limit) || ((limit - offset) < len_ext);
        end else begin
            // expand-down: valid range is (limit, upper]
            limit_fault = (offset <= limit) || (offset > upper) || ((upper - offset) < len_ext);
        end

        if (is_write) access_fault = is_code || !rw_bit;
        else          access_fault = is_code && !rw_bit;
    end

endmodule

// File: rtl/read_string.sv
// read_string: read-stage sequencer for string source operands
// (MOVS/LODS/CMPS/OUTS). Per iteration forms segment base + ESI, applies the
// REP count-zero ignore and source segment #GP checks, issues one handshaked
// memory read and presents size-masked data with the updated ESI.
//   clk, rst_n                 clock, synchronous active-low reset
//   rd_string_start/ready      iteration request / IDLE indication
//   rd_string_abort            pipeline flush (any state)
//   rd_is_8bit, rd_operand_16bit, rd_address_16bit, rd_prefix_group_1_rep,
//   rd_string_gp_fault_check, dflag, ecx, esi      operation attributes
//   seg_cache, seg_cache_valid, seg_base, seg_limit source segment
//   read_do/done/address/length/data               memory read handshake
//   rd_string_out_valid/accept                     result handshake
//   rd_string_data, rd_string_esi_final            result values
//   rd_string_ignore, rd_string_fault              no-read outcomes
module read_string
    import read_string_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_string_start,
    output logic        rd_string_ready,
    input  logic        rd_string_abort,
    input  logic        rd_is_8bit,
    input  logic        rd_operand_16bit,
    input  logic        rd_address_16bit,
    input  logic [1:0]  rd_prefix_group_1_rep,
    input  logic        rd_string_gp_fault_check,
    input  logic        dflag,
    input  logic [31:0] ecx,
    input  logic [31:0] esi,
    input  logic [63:0] seg_cache,
    input  logic        seg_cache_valid,
    input  logic [31:0] seg_base,
    input  logic [31:0] seg_limit,
    output logic        read_do,
    input  logic        read_done,
    output logic [31:0] read_address,
    output logic [2:0]  read_length,
    input  logic [31:0] read_data,
    output logic        rd_string_out_valid,
    input  logic        rd_string_out_accept,
    output logic [31:0] rd_string_data,
    output logic [31:0] rd_string_esi_final,
    output logic        rd_string_ignore,
    output logic        rd_string_fault
);

    state_t      state, state_next;

    logic [2:0]  size;
    logic [31:0] size32;
    logic [31:0] off;
    logic [15:0] esi16_new;
    logic [31:0] esi_new;
    logic [31:0] esi_new_q;
    logic        ignore_c;
    logic        fault_c;
    logic        limit_fault;
    logic        access_fault;

    string_seg_check u_seg_check (
        .offset       (off),
        .length_m1    (size - 3'd1),
        .cache        (seg_cache),
        .limit        (seg_limit),
        .is_write     (1'b0),
        .limit_fault  (limit_fault),
        .access_fault (access_fault)
    );

    always_comb begin
        size      = operand_size(rd_is_8bit, rd_operand_16bit);
        size32    = {29'd0, size};
        off       = rd_address_16bit ? {16'd0, esi[15:0]} : esi;
        esi16_new = dflag ? (esi[15:0] - size32[15:0]) : (esi[15:0] + size32[15:0]);
        if (rd_address_16bit) esi_new = {esi[31:16], esi16_new};
        else                  esi_new = dflag ? (esi - size32) : (esi + size32);

        ignore_c = (rd_prefix_group_1_rep != REP_NONE) &&
                   (rd_address_16bit ? (ecx[15:0] == 16'd0) : (ecx == 32'd0));
        fault_c  = !ignore_c && rd_string_gp_fault_check &&
                   (limit_fault || access_fault || !seg_cache_valid);
    end

    always_comb begin
        state_next = state;
        if (rd_string_abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (rd_string_start) state_next = (ignore_c || fault_c) ? ST_OUT : ST_READ;
                ST_READ: if (read_done)            state_next = ST_OUT;
                ST_OUT:  if (rd_string_out_accept) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            read_do             <= 1'b0;
            read_address        <= '0;
            read_length         <= '0;
            rd_string_data      <= '0;
            rd_string_esi_final <= '0;
            rd_string_ignore    <= 1'b0;
            rd_string_fault     <= 1'b0;
            esi_new_q           <= '0;
        end else begin
            state <= state_next;
            if (rd_string_abort) begin
                read_do             <= 1'b0;
                read_address        <= '0;
                read_length         <= '0;
                rd_string_data      <= '0;
                rd_string_esi_final <= '0;
                rd_string_ignore    <= 1'b0;
                rd_string_fault     <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: if (rd_string_start) begin
                        rd_string_data   <= '0;
                        rd_string_ignore <= ignore_c;
                        rd_string_fault  <= fault_c;
                        if (ignore_c || fault_c) begin
                            rd_string_esi_final <= esi;
                        end else begin
                            read_do      <= 1'b1;
                            read_address <= seg_base + off;
                            read_length  <= size;
                            esi_new_q    <= esi_new;
                        end
                    end
                    ST_READ: if (read_done) begin
                        read_do             <= 1'b0;
                        rd_string_esi_final <= esi_new_q;
                        unique case (read_length)
                            3'd1:    rd_string_data <= {24'd0, read_data[7:0]};
                            3'd2:    rd_string_data <= {16'd0, read_data[15:0]};
                            default: rd_string_data <= read_data;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_string_ready     = (state == ST_IDLE);
    assign rd_string_out_valid = (state == ST_OUT);

endmodule

// File: tb/tb_read_string.sv
module tb_read_string;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_string_start;
    logic        rd_string_ready;
    logic        rd_string_abort;
    logic        rd_is_8bit;
    logic        rd_operand_16bit;
    logic        rd_address_16bit;
    logic [1:0]  rd_prefix_group_1_rep;
    logic        rd_string_gp_fault_check;
    logic        dflag;
    logic [31:0] ecx;
    logic [31:0] esi;
    logic [63:0] seg_cache;
    logic        seg_cache_valid;
    logic [31:0] seg_base;
    logic [31:0] seg_limit;
    logic        read_do;
    logic        read_done;
    logic [31:0] read_address;
    logic [2:0]  read_length;
    logic [31:0] read_data;
    logic        rd_string_out_valid;
    logic        rd_string_out_accept;
    logic [31:0] rd_string_data;
    logic [31:0] rd_string_esi_final;
    logic        rd_string_ignore;
    logic        rd_string_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    read_string dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .rd_string_start          (rd_string_start),
        .rd_string_ready          (rd_string_ready),
        .rd_string_abort          (rd_string_abort),
        .rd_is_8bit               (rd_is_8bit),
        .rd_operand_16bit         (rd_operand_16bit),
        .rd_address_16bit         (rd_address_16bit),
        .rd_prefix_group_1_rep    (rd_prefix_group_1_rep),
        .rd_string_gp_fault_check (rd_string_gp_fault_check),
        .dflag                    (dflag),
        .ecx                      (ecx),
        .esi                      (esi),
        .seg_cache                (seg_cache),
        .seg_cache_valid          (seg_cache_valid),
        .seg_base                 (seg_base),
        .seg_limit                (seg_limit),
        .read_do                  (read_do),
        .read_done                (read_done),
        .read_address             (read_address),
        .read_length              (read_length),
        .read_data                (read_data),
        .rd_string_out_valid      (rd_string_out_valid),
        .rd_string_out_accept     (rd_string_out_accept),
        .rd_string_data           (rd_string_data),
        .rd_string_esi_final      (rd_string_esi_final),
        .rd_string_ignore         (rd_string_ignore),
        .rd_string_fault          (rd_string_fault)
    );

    // Descriptor caches: bit 54 D/B, 43 code, 42 expand-down, 41 R/W
    localparam logic [63:0] C_EU32   = 64'h0040_0200_0000_0000; // data, RW, D/B=1
    localparam logic [63:0] C_EU16   = 64'h0000_0200_0000_0000; // data, RW, D/B=0
    localparam logic [63:0] C_ED16   = 64'h0000_0600_0000_0000; // data, RW, expand-down, D/B=0
    localparam logic [63:0] C_XONLY  = 64'h0040_0800_0000_0000; // execute-only code

    typedef struct {
        logic        is8, op16, addr16;
        logic [1:0]  rep;
        logic        gp, dfl, valid;
        logic [31:0] ecx, esi;
        logic [63:0] cache;
        logic [31:0] base, limit, rdata;
        int          lat;
        logic        e_ign, e_flt, e_read;
        logic [31:0] e_addr;
        logic [2:0]  e_len;
        logic [31:0] e_data, e_esi;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        rd_is_8bit               = v.is8;
        rd_operand_16bit         = v.op16;
        rd_address_16bit         = v.addr16;
        rd_prefix_group_1_rep    = v.rep;
        rd_string_gp_fault_check = v.gp;
        dflag                    = v.dfl;
        seg_cache_valid          = v.valid;
        ecx                      = v.ecx;
        esi                      = v.esi;
        seg_cache                = v.cache;
        seg_base                 = v.base;
        seg_limit                = v.limit;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, "_ready"}, 64'(rd_string_ready), 64'd1);
        drive(v);
        rd_string_start = 1'b1;
        tick();
        rd_string_start = 1'b0;
        if (!v.e_read) begin
            chk({p, "_valid_lat1"}, 64'(rd_string_out_valid), 64'd1);
            chk({p, "_no_read"}, 64'(read_do), 64'd0);
        end else begin
            chk({p, "_read_do"}, 64'(read_do), 64'd1);
            chk({p, "_addr"}, 64'(read_address), 64'(v.e_addr));
            chk({p, "_len"}, 64'(read_length), 64'(v.e_len));
            for (int c = 1; c < v.lat; c++) begin
                tick();
                chk({p, "_read_do_held"}, 64'(read_do), 64'd1);
                chk({p, "_addr_held"}, 64'(read_address), 64'(v.e_addr));
                chk({p, "_valid_early"}, 64'(rd_string_out_valid), 64'd0);
            end
            read_done = 1'b1;
            read_data = v.rdata;
            tick();
            read_done = 1'b0;
            read_data = '0;
            chk({p, "_read_do_drop"}, 64'(read_do), 64'd0);
            chk({p, "_valid"}, 64'(rd_string_out_valid), 64'd1);
        end
        chk({p, "_ignore"}, 64'(rd_string_ignore), 64'(v.e_ign));
        chk({p, "_fault"}, 64'(rd_string_fault), 64'(v.e_flt));
        chk({p, "_data"}, 64'(rd_string_data), 64'(v.e_data));
        chk({p, "_esi"}, 64'(rd_string_esi_final), 64'(v.e_esi));
        // results held without accept; a start in OUT must be ignored
        rd_string_start = 1'b1;
        tick();
        tick();
        rd_string_start = 1'b0;
        chk({p, "_valid_held"}, 64'(rd_string_out_valid), 64'd1);
        chk({p, "_no_restart"}, 64'(read_do), 64'd0);
        chk({p, "_data_held"}, 64'(rd_string_data), 64'(v.e_data));
        chk({p, "_esi_held"}, 64'(rd_string_esi_final), 64'(v.e_esi));
        rd_string_out_accept = 1'b1;
        tick();
        rd_string_out_accept = 1'b0;
        chk({p, "_valid_drop"}, 64'(rd_string_out_valid), 64'd0);
        chk({p, "_ready_back"}, 64'(rd_string_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_string_start = 1'b0;
        rd_string_abort = 1'b0;
        read_done = 1'b0;
        read_data = '0;
        rd_string_out_accept = 1'b0;
        drive('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0,
                32'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0});

        //            is8   op16  a16   rep   gp    dfl   valid ecx            esi            cache    base           limit          rdata          lat  ign   flt   read  addr           len   data           esi_final
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0,         32'h0000_0100, C_EU32,  32'h0000_1000, 32'h0000_FFFF, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 1'b1, 32'h0000_1100, 3'd4, 32'hDEAD_BEEF, 32'h0000_0104});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'd0,         32'hABCD_0000, C_EU32,  32'h0000_2000, 32'h0000_FFFF, 32'h1234_5678, 2, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 3'd1, 32'h0000_0078, 32'hABCD_FFFF});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0000_0055, C_EU32,  32'h0000_2000, 32'h0000_FFFF, 32'd0,         1, 1'b1, 1'b0, 1'b0, 32'd0,         3'd0, 32'd0,         32'h0000_0055});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0,         32'h0000_0FFE, C_EU32,  32'h0000_1000, 32'h0000_0FFF, 32'd0,         1, 1'b0, 1'b1, 1'b0, 32'd0,         3'd0, 32'd0,         32'h0000_0FFE});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'd0,         32'h0000_0FFE, C_EU32,  32'h0000_1000, 32'h0000_0FFF, 32'hCAFE_F00D, 1, 1'b0, 1'b0, 1'b1, 32'h0000_1FFE, 3'd4, 32'hCAFE_F00D, 32'h0000_1002});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0,         32'h0000_0800, C_ED16,  32'h0003_0000, 32'h0000_0FFF, 32'd0,         1, 1'b0, 1'b1, 1'b0, 32'd0,         3'd0, 32'd0,         32'h0000_0800});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0,         32'h0000_FFFD, C_ED16,  32'h0003_0000, 32'h0000_0FFF, 32'hAAAA_1234, 2, 1'b0, 1'b0, 1'b1, 32'h0003_FFFD, 3'd2, 32'h0000_1234, 32'h0000_FFFF});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0,         32'h0000_FFFE, C_ED16,  32'h0003_0000, 32'h0000_0FFF, 32'd0,         1, 1'b0, 1'b1, 1'b0, 32'd0,         3'd0, 32'd0,         32'h0000_FFFE});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 32'd0,         32'h0000_0000, C_EU32,  32'h0000_0010, 32'hFFFF_FFFF, 32'h5555_BEEF, 1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 3'd2, 32'h0000_BEEF, 32'hFFFF_FFFE});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 32'd0,         32'h0000_0040, C_XONLY, 32'h0000_0000, 32'h0000_FFFF, 32'd0,         1, 1'b1, 1'b0, 1'b0, 32'd0,         3'd0, 32'd0,         32'h0000_0040});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0,         32'h0000_0040, C_XONLY, 32'h0000_0000, 32'h0000_FFFF, 32'd0,         1, 1'b0, 1'b1, 1'b0, 32'd0,         3'd0, 32'd0,         32'h0000_0040});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0,         32'h0000_0040, C_EU32,  32'h0000_0000, 32'h0000_FFFF, 32'd0,         1, 1'b0, 1'b1, 1'b0, 32'd0,         3'd0, 32'd0,         32'h0000_0040});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h0001_0001, 32'h1234_FFFF, C_EU16,  32'h0000_0000, 32'h0000_FFFF, 32'h0000_0099, 2, 1'b0, 1'b0, 1'b1, 32'h0000_FFFF, 3'd1, 32'h0000_0099, 32'h1234_0000});

        // reset state
        tick();
        chk("rst_ready", 64'(rd_string_ready), 64'd1);
        chk("rst_read_do", 64'(read_do), 64'd0);
        chk("rst_valid", 64'(rd_string_out_valid), 64'd0);
        chk("rst_outs", {read_address, rd_string_data}, 64'd0);
        chk("rst_misc", {rd_string_esi_final, 29'd0, read_length}, 64'd0);
        chk("rst_flags", {62'd0, rd_string_ignore, rd_string_fault}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // abort coinciding with read_done: data discarded, back to IDLE
        drive(vecs[0]);
        rd_string_start = 1'b1;
        tick();
        rd_string_start = 1'b0;
        chk("ab_read_do", 64'(read_do), 64'd1);
        rd_string_abort = 1'b1;
        read_done = 1'b1;
        read_data = 32'h1111_2222;
        tick();
        rd_string_abort = 1'b0;
        chk("ab_ready", 64'(rd_string_ready), 64'd1);
        chk("ab_read_do_drop", 64'(read_do), 64'd0);
        chk("ab_valid", 64'(rd_string_out_valid), 64'd0);
        chk("ab_data", 64'(rd_string_data), 64'd0);
        tick();  // stray read_done while IDLE
        read_done = 1'b0;
        read_data = '0;
        tick();
        chk("ab_stray_valid", 64'(rd_string_out_valid), 64'd0);
        chk("ab_stray_ready", 64'(rd_string_ready), 64'd1);
        chk("ab_stray_data", 64'(rd_string_data), 64'd0);

        // abort in OUT clears flags and result
        drive(vecs[3]);
        rd_string_start = 1'b1;
        tick();
        rd_string_start = 1'b0;
        chk("abo_fault", 64'(rd_string_fault), 64'd1);
        rd_string_abort = 1'b1;
        rd_string_out_accept = 1'b1;
        tick();
        rd_string_abort = 1'b0;
        rd_string_out_accept = 1'b0;
        chk("abo_valid", 64'(rd_string_out_valid), 64'd0);
        chk("abo_fault_clr", 64'(rd_string_fault), 64'd0);
        chk("abo_esi_clr", 64'(rd_string_esi_final), 64'd0);

        // abort beats simultaneous start in IDLE
        rd_string_start = 1'b1;
        rd_string_abort = 1'b1;
        tick();
        rd_string_start = 1'b0;
        rd_string_abort = 1'b0;
        chk("abs_ready", 64'(rd_string_ready), 64'd1);
        chk("abs_valid", 64'(rd_string_out_valid), 64'd0);

        // mid-operation reset
        drive(vecs[0]);
        rd_string_start = 1'b1;
        tick();
        rd_string_start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_read_do", 64'(read_do), 64'd0);
        chk("mrst_ready", 64'(rd_string_ready), 64'd1);
        chk("mrst_addr", 64'(read_address), 64'd0);

        // normal operation resumes after the flushes
        tick();
        run_vec(vecs[1], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_string.md
Name: read_string

Overview:
- Read-stage sequencer for string source operands (MOVS/LODS/CMPS/OUTS). It is the read-side counterpart of the write-stage string ES logic.
- Per iteration it takes a start request and forms the source linear address (segment base + ESI). It performs the REP-count ignore check and the segment limit/readability fault check.
- If there is no fault, it issues one handshaked memory read. It returns size-masked data, the updated ESI and status flags through a held valid/accept output.

Parameters:
- none (operand sizes fixed at 1/2/4 bytes; descriptor bit positions come from the shared defines)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rd_string_start  in  1  start one iteration; sampled only when rd_string_ready=1
- rd_string_ready  out  1  high only in IDLE
- rd_string_abort  in  1  pipeline flush
- rd_is_8bit  in  1  byte operand
- rd_operand_16bit  in  1  word operand (when not 8-bit)
- rd_address_16bit  in  1  16-bit addressing; 0 = 32-bit
- rd_prefix_group_1_rep  in  2  0 = none, 1 = REPZ, 2 = REPNZ
- rd_string_gp_fault_check  in  1  enable segment checks
- dflag  in  1  direction flag
- ecx  in  32  count register
- esi  in  32  source index
- seg_cache  in  64  source segment descriptor cache (DS or override)
- seg_cache_valid  in  1  descriptor valid
- seg_base  in  32  segment base
- seg_limit  in  32  segment limit
- read_do  out  1  memory read request, held until read_done
- read_done  in  1  read completion
- read_address  out  32  linear address
- read_length  out  3  1, 2 or 4
- read_data  in  32  read result, valid with read_done
- rd_string_out_valid  out  1  result valid, held until accepted
- rd_string_out_accept  in  1  consumer takes result
- rd_string_data  out  32  zero-extended operand
- rd_string_esi_final  out  32  updated ESI
- rd_string_ignore  out  1  REP with count 0: no read performed
- rd_string_fault  out  1  #GP on source segment: no read performed

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0 except rd_string_ready=1.
- States: IDLE, READ, OUT.
- IDLE, start=1, abort=0: capture all inputs and compute:
  - size = 1/2/4 (8-bit, else 16-bit, else 32-bit).
  - off = rd_address_16bit ? {16'd0, esi[15:0]} : esi.
  - ignore = rep!=0 && (addr16 ? ecx[15:0]==0 : ecx==0).
  - esi_new = dflag ? esi-size : esi+size; with addr16 the upper 16 bits keep esi[31:16]. Wrap is mod 2^16 or mod 2^32 respectively.
  - upper = seg_cache[DESC_BIT_D_B] ? FFFFFFFF : 0000FFFF.
  - Code or expand-up (cache[43] || !cache[42]): fault terms are off > limit, and limit-off < size-1 (unsigned).
  - Expand-down data: fault terms are off <= limit, off > upper, and upper-off < size-1.
  - Also a fault when !seg_cache_valid, or for an execute-only code segment (cache[43] && !cache[41]).
  - fault = !ignore && gp_fault_check && any of the above terms. Ignore has priority over fault.
- Transitions out of IDLE:
  - If ignore or fault: go to OUT next cycle with data=0 and the flag set; esi_final = esi unchanged. No read is issued.
  - Otherwise: go to READ. read_do=1, read_address = seg_base+off (mod 2^32) and read_length=size are registered in the next cycle.
- READ:
  - read_do, read_address and read_length are held stable until read_done.
  - On read_done: latch data (8-bit → {24'd0, [7:0]}; 16-bit → {16'd0, [15:0]}; 32-bit → as is) and esi_new.
  - Next cycle: read_do=0, state OUT.
- OUT:
  - out_valid=1 and all result outputs are held stable.
  - out_accept=1 → IDLE next cycle; ready returns the cycle after the accept.
  - Start is not sampled in OUT.
- Latency: start to out_valid is 1 cycle for ignore/fault. For a read it is 1 cycle plus the memory latency; out_valid rises the cycle after read_done.
- Abort, at any state: IDLE next cycle. read_do and out_valid drop, and results clear to 0.
  - Abort wins over a simultaneous start, read_done or accept.
  - A read_done arriving while in IDLE is ignored.
- Start while not in IDLE is ignored.
- Mid-operation reset behaves like abort and additionally restores reset values.

Decomposition:
- Shared defines: DESC_BIT_D_B and the descriptor type-bit indices (41 readable/writable, 42 expand-down/conforming, 43 code), the state encodings, and the REP prefix codes (NONE=0, REPZ=1, REPNZ=2).
- One combinational sub-module, string_seg_check:
  - Inputs: offset, length-1, descriptor cache, limit, and a write/read select.
  - Outputs: limit-fault and access-fault.
  - Reusable by the write-stage ES check.

Test Plan:
- 32-bit addressing, dflag=0, 32-bit operand, esi=0x100, base=0x1000, limit=0xFFFF, read_done after 3 cycles with 0xDEADBEEF → read_address 0x1100, length 4, data 0xDEADBEEF, esi_final 0x104, out_valid held until accept.
- 16-bit addressing, 8-bit operand, dflag=1, esi=0xABCD0000, read_data 0x12345678 → read_address base+0, esi_final 0xABCDFFFF, data 0x00000078.
- REPZ, 16-bit addressing, ecx=0x00010000 → ignore=1 one cycle after start, read_do never asserted, esi_final = esi.
- Expand-up, limit=0x0FFF, 32-bit operand, offset 0x0FFE, gp_check=1 → fault=1, no read. Same stimulus with gp_check=0 → read issued.
- Expand-down, D/B=0, limit=0x0FFF: offset 0x0800 → fault; offset 0xFFFD with 16-bit operand → read; offset 0xFFFE with 32-bit operand → fault.
- Abort asserted in the same cycle as read_done → IDLE next cycle, out_valid stays 0, data discarded; a later read_done is ignored.
